// File: rtl/fetch_unpacker.sv
// fetch_unpacker: buffers 64-bit bus response beats in a small FIFO and
// hands them to decode as two 32-bit instructions each (low half first),
// tagged with a running PC. An all-zero instruction word raises a sticky halt.
//
// Handshakes:
//   bus side    - a beat moves when bus_respcyc & bus_respack (respack is
//                 combinational: respcyc & !full & !halt).
//   decode side - an instruction moves when inst_valid & inst_ready.
//                 inst/inst_pc hold steady while inst_valid is high and
//                 inst_ready is low.
module fetch_unpacker #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DEPTH          = 4,
    parameter int BEATS_PER_LINE = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      line_start,
    input  logic [63:0]               line_base,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic                      bus_respack,
    output logic                      inst_valid,
    output logic [31:0]               inst,
    output logic [63:0]               inst_pc,
    input  logic                      inst_ready,
    output logic                      line_done,
    output logic                      halt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS_PER_LINE - 1);

    logic [BUS_DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]               wptr;
    logic [AW:0]               rptr;
    logic                      sel;
    logic [CW-1:0]             beat_cnt;

    logic                      full;
    logic                      empty;
    logic                      accept;
    logic                      xfer;
    logic                      pop;
    logic [BUS_DATA_WIDTH-1:0] head;
    logic [CW-1:0]             cnt_base;

    // FIFO status, half-word selection and both handshakes
    always_comb begin
        empty       = (wptr == rptr);
        full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        head        = mem[rptr[AW-1:0]];
        inst        = empty ? 32'h0 : (sel ? head[63:32] : head[31:0]);
        inst_valid  = !empty && !halt && (inst != 32'h0);
        bus_respack = bus_respcyc && !full && !halt;
        accept      = bus_respack;
        // a flush discards any transfer offered in the same cycle
        xfer        = inst_valid && inst_ready && !line_start;
        pop         = xfer && sel;
        // a flush restarts the beat count before this cycle's beat is counted
        cnt_base    = line_start ? '0 : beat_cnt;
    end

    // Beat storage; a beat accepted during a flush lands in entry 0
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[line_start ? '0 : wptr[AW-1:0]] <= bus_resp;
        end
    end

    // Pointers, half select, PC, beat counter, line_done and halt
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            sel       <= 1'b0;
            inst_pc   <= 64'h0;
            beat_cnt  <= '0;
            line_done <= 1'b0;
            halt      <= 1'b0;
        end else begin
            if (line_start) begin
                wptr    <= accept ? (AW+1)'(1) : '0;
                rptr    <= '0;
                sel     <= 1'b0;
                inst_pc <= line_base;
            end else begin
                if (accept) wptr <= wptr + 1'b1;
                if (pop)    rptr <= rptr + 1'b1;
                if (xfer) begin
                    sel     <= ~sel;
                    inst_pc <= inst_pc + 64'd4;
                end
            end

            if (accept) begin
                beat_cnt <= (cnt_base == LAST_BEAT) ? '0 : cnt_base + 1'b1;
            end else begin
                beat_cnt <= cnt_base;
            end

            line_done <= accept && (cnt_base == LAST_BEAT);
            // the zero word sits in the selected half-slot: stop for good
            halt      <= halt || (!empty && (inst == 32'h0));
        end
    end

endmodule

// File: tb/tb_fetch_unpacker.sv
// Bench for fetch_unpacker: a directed vector table, hand-written corner
// sequences and a randomized phase, all checked every cycle against a
// word-queue reference model.
module tb_fetch_unpacker;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        line_start;
    logic [63:0] line_base;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic        bus_respack;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;
    logic        line_done;
    logic        halt;

    // clock
    always #5 clk = ~clk;

    fetch_unpacker #(.BUS_DATA_WIDTH(64), .DEPTH(DEPTH), .BEATS_PER_LINE(8)) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .line_base(line_base),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_respack(bus_respack),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .line_done(line_done), .halt(halt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: instruction words still to be presented, in order
    logic [31:0] exp_q[$];
    logic [63:0] m_pc;
    bit          m_halt;
    bit          m_done;
    int          m_cnt;

    // values sampled in the most recent step
    bit          s_ack, s_valid, s_done, s_halt;
    logic [31:0] s_inst;
    logic [63:0] s_pc;

    typedef struct {
        bit          ls;
        logic [63:0] base;
        bit          cyc;
        logic [63:0] data;
        bit          rdy;
        bit          e_ack;
        bit          e_valid;
        logic [31:0] e_inst;
        logic [63:0] e_pc;
        bit          e_done;
        bit          e_halt;
    } vec_t;

    vec_t vecs[5];
    vec_t cur;
    bit   use_vec = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_inst();
        return (exp_q.size() == 0) ? 32'h0 : exp_q[0];
    endfunction

    function automatic bit m_valid();
        return (exp_q.size() > 0) && !m_halt && (exp_q[0] != 32'h0);
    endfunction

    // a beat occupies a slot until both of its words are gone
    function automatic bit m_ack(input bit cyc);
        return cyc && (((exp_q.size() + 1) / 2) < DEPTH) && !m_halt;
    endfunction

    // one clock cycle: drive, sample at negedge, check, advance the model
    task automatic step(input bit rst, input bit ls, input logic [63:0] base,
                        input bit cyc, input logic [63:0] data, input bit rdy,
                        input bit chk);
        bit acc, xf, hnext, dnext;
        int eff;
        reset = rst; line_start = ls; line_base = base;
        bus_respcyc = cyc; bus_resp = data; inst_ready = rdy;
        @(negedge clk);
        s_ack = bus_respack; s_valid = inst_valid; s_inst = inst;
        s_pc = inst_pc; s_done = line_done; s_halt = halt;
        if (chk) begin
            check("respack", bus_respack, m_ack(cyc));
            check("inst_valid", inst_valid, m_valid());
            check("inst", inst, m_inst());
            check("inst_pc", inst_pc, m_pc);
            check("line_done", line_done, m_done);
            check("halt", halt, m_halt);
        end
        if (use_vec) begin
            check("vec_respack", bus_respack, cur.e_ack);
            check("vec_valid", inst_valid, cur.e_valid);
            check("vec_inst", inst, cur.e_inst);
            check("vec_pc", inst_pc, cur.e_pc);
            check("vec_done", line_done, cur.e_done);
            check("vec_halt", halt, cur.e_halt);
        end
        if (rst) begin
            exp_q.delete();
            m_pc = 64'h0; m_halt = 1'b0; m_done = 1'b0; m_cnt = 0;
        end else begin
            acc   = m_ack(cyc);
            xf    = m_valid() && rdy && !ls;
            hnext = m_halt || ((exp_q.size() > 0) && (exp_q[0] == 32'h0));
            eff   = ls ? 0 : m_cnt;
            dnext = acc && (eff == 7);
            if (ls) begin
                exp_q.delete();
                m_pc = base;
            end else if (xf) begin
                exp_q.delete(0);
                m_pc = m_pc + 64'd4;
            end
            if (acc) begin
                exp_q.push_back(data[31:0]);
                exp_q.push_back(data[63:32]);
                eff = (eff + 1) % 8;
            end
            m_cnt = eff; m_halt = hnext; m_done = dnext;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, rdy, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1);
    endtask

    initial begin
        int acks, xfers, dones, beat, budget;
        logic [63:0] d;

        // clock/reset: first cycle from unknown state is not checked
        step(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        // reset values, with respcyc high so respack must follow it
        step(1'b0, 1'b0, 64'h0, 1'b1, 64'h0, 1'b0, 1'b0);
        check("rst_respack", s_ack, 1'b1);
        check("rst_valid", s_valid, 1'b0);
        check("rst_inst", s_inst, 32'h0);
        check("rst_pc", s_pc, 64'h0);
        check("rst_done", s_done, 1'b0);
        check("rst_halt", s_halt, 1'b0);
        do_reset();

        // directed table: one beat through to decode
        vecs[0] = '{1'b1, 64'h1000, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 64'h0, 1'b1, 64'h00000013_00500093, 1'b1,
                    1'b1, 1'b0, 32'h0, 64'h1000, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 32'h00500093, 64'h1000, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 32'h00000013, 64'h1004, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 32'h0, 64'h1008, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            cur = vecs[i];
            use_vec = 1'b1;
            step(1'b0, cur.ls, cur.base, cur.cyc, cur.data, cur.rdy, 1'b1);
            use_vec = 1'b0;
        end

        // full line of 8 beats with decode always ready
        step(1'b0, 1'b1, 64'h1000, 1'b0, 64'h0, 1'b1, 1'b1);
        beat = 0; xfers = 0; dones = 0; budget = 0;
        while ((xfers < 16 || budget < 40) && budget < 60) begin
            d = {32'(32'h100 + 2 * beat + 1), 32'(32'h100 + 2 * beat)};
            step(1'b0, 1'b0, 64'h0, beat < 8, d, 1'b1, 1'b1);
            if (beat < 8 && s_ack) beat++;
            if (s_valid) begin
                check("line_pc", s_pc, 64'h1000 + 64'(4 * xfers));
                check("line_inst", s_inst, 32'(32'h100 + xfers));
                xfers++;
            end
            if (s_done) dones++;
            budget++;
        end
        check("line_xfers", xfers, 16);
        check("line_done_pulses", dones, 1);

        // fill with decode stalled
        step(1'b0, 1'b1, 64'h3000, 1'b0, 64'h0, 1'b0, 1'b1);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 64'h0, 1'b1, 64'h2222_0000_1111_0000 + 64'(i + 1), 1'b0, 1'b1);
            if (s_ack) acks++;
        end
        check("full_acks", acks, DEPTH);
        step(1'b0, 1'b0, 64'h0, 1'b1, 64'h5555_0001_5555_0001, 1'b1, 1'b1);
        check("full_ack_lo", s_ack, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b1, 64'h5555_0001_5555_0001, 1'b1, 1'b1);
        check("full_ack_pop", s_ack, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b1, 64'h5555_0001_5555_0001, 1'b0, 1'b1);
        check("full_ack_after", s_ack, 1'b1);

        // zero high half halts the stream
        do_reset();
        step(1'b0, 1'b1, 64'h1000, 1'b0, 64'h0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1, 64'h00000000_00A00513, 1'b1, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1);
        check("halt_lo_inst", s_inst, 32'h00A00513);
        check("halt_lo_valid", s_valid, 1'b1);
        idle(1'b1);
        check("halt_zero_valid", s_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 64'h0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1);
            check("halted_halt", s_halt, 1'b1);
            check("halted_ack", s_ack, 1'b0);
        end
        step(1'b0, 1'b1, 64'h4000, 1'b0, 64'h0, 1'b1, 1'b1);
        idle(1'b1);
        check("halt_after_flush", s_halt, 1'b1);
        do_reset();
        idle(1'b1);
        check("halt_cleared", s_halt, 1'b0);

        // flush with 3 beats buffered and a beat arriving the same cycle
        step(1'b0, 1'b1, 64'h1000, 1'b0, 64'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 64'h0, 1'b1, 64'hAAAA_0000_BBBB_0000 + 64'(i + 1), 1'b0, 1'b1);
        step(1'b0, 1'b1, 64'h2000, 1'b1, 64'h0000_0777_0000_0666, 1'b1, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b1);
        check("flush_inst", s_inst, 32'h0000_0666);
        check("flush_pc", s_pc, 64'h2000);
        check("flush_valid", s_valid, 1'b1);
        // beat count resumed at 1: seven more beats complete the line
        dones = 0; beat = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 64'h0, beat < 7, 64'h0000_0900_0000_0800 + 64'(beat), 1'b1, 1'b1);
            if (beat < 7 && s_ack) beat++;
            if (s_done) dones++;
        end
        check("flush_line_done", dones, 1);

        // reset mid-line with 2 beats buffered
        step(1'b0, 1'b1, 64'h5000, 1'b0, 64'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1, 64'h0000_0042_0000_0041, 1'b0, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1, 64'h0000_0044_0000_0043, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check("midrst_valid", s_valid, 1'b0);
            check("midrst_inst", s_inst, 32'h0);
            check("midrst_pc", s_pc, 64'h0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit rst, ls, cyc, rdy;
            logic [31:0] lo, hi;
            rst = ($urandom_range(0, 99) == 0) || (m_halt && $urandom_range(0, 3) == 0);
            ls  = ($urandom_range(0, 24) == 0);
            cyc = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            lo  = ($urandom_range(0, 59) == 0) ? 32'h0 : ($urandom | 32'h1);
            hi  = ($urandom_range(0, 59) == 0) ? 32'h0 : ($urandom | 32'h1);
            step(rst, ls, {$urandom, $urandom}, cyc, {hi, lo}, rdy, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
